// File: rtl/membus_pkg.sv
// rtl/membus_pkg.sv - shared encodings for the CPU/DMA memory bus arbiter
package membus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - round-robin CPU/DMA arbiter for the shared 8-bit memory bus
module membus_arbiter
  import membus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned LOCK_MAX    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_lock,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [7:0]  rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [3:0] LM = 4'(LOCK_MAX);

  state_t     state;
  logic [3:0] wcnt;
  logic       owner;
  logic       last_winner;
  logic       lock_active;
  logic [3:0] lock_cnt;
  logic       win;

  // A held lock keeps the CPU ahead until lock_cnt reaches LOCK_MAX, then plain round-robin resumes.
  always_comb begin
    win = REQ_CPU;
    if (cpu_req && dma_req) begin
      if (lock_active && lock_cnt < LM) win = REQ_CPU;
      else win = (last_winner == REQ_CPU) ? REQ_DMA : REQ_CPU;
    end else if (dma_req) begin
      win = REQ_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wcnt        <= 4'd0;
      owner       <= REQ_CPU;
      last_winner <= REQ_DMA;
      lock_active <= 1'b0;
      lock_cnt    <= 4'd0;
      cpu_gnt     <= 1'b0;
      dma_gnt     <= 1'b0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wdata   <= 8'h00;
      rdata       <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req || dma_req) begin
            owner       <= win;
            last_winner <= win;
            cpu_gnt     <= (win == REQ_CPU);
            dma_gnt     <= (win == REQ_DMA);
            mem_en      <= 1'b1;
            mem_we      <= (win == REQ_DMA) ? dma_we : cpu_we;
            mem_addr    <= (win == REQ_DMA) ? dma_addr : cpu_addr;
            mem_wdata   <= (win == REQ_DMA) ? dma_wdata : cpu_wdata;
            wcnt        <= WS;
            state       <= ST_ACCESS;
            // The locking grant itself counts, so LOCK_MAX is the total run of contested CPU grants.
            if (win == REQ_CPU) begin
              lock_active <= cpu_lock;
              if (!cpu_lock) lock_cnt <= 4'd0;
              else if (dma_req) lock_cnt <= lock_cnt + 4'd1;
            end else begin
              lock_cnt <= 4'd0;
            end
          end
        end
        ST_ACCESS: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            if (!mem_we) rdata <= mem_rdata;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_gnt <= 1'b0;
            dma_gnt <= 1'b0;
            cpu_ack <= (owner == REQ_CPU);
            dma_ack <= (owner == REQ_DMA);
            state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - self-checking bench for membus_arbiter
module tb_membus_arbiter;

  localparam int WS1 = 1;
  localparam int LOCK_MAX1 = 4;

  logic clk, rst;
  logic cpu_req, cpu_lock, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0] cpu_wdata, dma_wdata, mem_rdata, rdata_drv;
  logic use_fn;
  logic cpu_gnt, cpu_ack, dma_gnt, dma_ack, mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata, rdata;
  logic cpu_gnt_z, cpu_ack_z, dma_gnt_z, dma_ack_z, mem_en_z, mem_we_z;
  logic [15:0] mem_addr_z;
  logic [7:0] mem_wdata_z, rdata_z;
  int checks = 0;
  int fails = 0;

  function automatic logic [7:0] fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign mem_rdata = use_fn ? fn(mem_addr) : rdata_drv;

  membus_arbiter #(.WAIT_STATES(WS1), .LOCK_MAX(LOCK_MAX1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  membus_arbiter #(.WAIT_STATES(0), .LOCK_MAX(LOCK_MAX1)) dut_z (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt_z), .cpu_ack(cpu_ack_z),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_z), .dma_ack(dma_ack_z),
    .rdata(rdata_z), .mem_en(mem_en_z), .mem_we(mem_we_z), .mem_addr(mem_addr_z), .mem_wdata(mem_wdata_z),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; cpu_lock = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic collect_grants(input int cnt, input logic lock, output logic [15:0] order,
                                output int got, output logic both);
    int acks;
    logic pc, pd;
    order = '0; got = 0; both = 1'b0; acks = 0; pc = 1'b0; pd = 1'b0;
    cpu_lock = lock; cpu_we = 1'b0; dma_we = 1'b0; cpu_req = 1'b1; dma_req = 1'b1;
    for (int c = 0; c < cnt * 8 + 20 && acks < cnt; c++) begin
      tick;
      if (cpu_gnt && dma_gnt) both = 1'b1;
      if (cpu_gnt && !pc && got < 16) begin order[got] = 1'b0; got++; end
      if (dma_gnt && !pd && got < 16) begin order[got] = 1'b1; got++; end
      pc = cpu_gnt; pd = dma_gnt;
      if (cpu_ack || dma_ack) begin
        acks++;
        if (cpu_ack) cpu_req = 1'b0;
        if (dma_ack) dma_req = 1'b0;
      end else if (got < cnt) begin
        cpu_req = 1'b1; dma_req = 1'b1;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0; cpu_lock = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    logic [5:0] ctl;
    do_reset;
    ctl = {cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_en, mem_we};
    checks++; if (ctl !== 6'b0) begin fails++; $display("FAIL reset_ctl got=%b exp=000000", ctl); end
    checks++; if ({mem_addr, mem_wdata, rdata} !== 32'h0) begin
      fails++; $display("FAIL reset_data got=%h/%h/%h exp=0000/00/00", mem_addr, mem_wdata, rdata); end
    ctl = {cpu_gnt_z, dma_gnt_z, cpu_ack_z, dma_ack_z, mem_en_z, mem_we_z};
    checks++; if (ctl !== 6'b0) begin fails++; $display("FAIL reset_ctl_z got=%b exp=000000", ctl); end
  endtask

  task automatic test_cpu_read;
    use_fn = 1'b0; rdata_drv = 8'hA5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00; cpu_lock = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick;
      checks++; if ({mem_en, cpu_gnt, dma_gnt, mem_we} !== 4'b1100) begin
        fails++; $display("FAIL cpu_read_access T+%0d en/cg/dg/we got=%b exp=1100", k, {mem_en, cpu_gnt, dma_gnt, mem_we}); end
      checks++; if (mem_addr !== 16'h1234) begin
        fails++; $display("FAIL cpu_read_addr T+%0d got=%h exp=1234", k, mem_addr); end
    end
    tick;
    checks++; if ({cpu_ack, dma_ack, mem_en, cpu_gnt} !== 4'b1000) begin
      fails++; $display("FAIL cpu_read_ack ack/dack/en/gnt got=%b exp=1000", {cpu_ack, dma_ack, mem_en, cpu_gnt}); end
    checks++; if (rdata !== 8'hA5) begin fails++; $display("FAIL cpu_read_rdata got=%h exp=a5", rdata); end
    cpu_req = 1'b0;
    tick;
  endtask

  task automatic test_dma_write;
    rdata_drv = 8'h11;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h8000; dma_wdata = 8'h5A;
    for (int k = 1; k <= 2; k++) begin
      tick;
      checks++; if ({mem_en, mem_we, dma_gnt, cpu_gnt} !== 4'b1110) begin
        fails++; $display("FAIL dma_write_access T+%0d en/we/dg/cg got=%b exp=1110", k, {mem_en, mem_we, dma_gnt, cpu_gnt}); end
      checks++; if ({mem_addr, mem_wdata} !== 24'h80005A) begin
        fails++; $display("FAIL dma_write_bus T+%0d got=%h/%h exp=8000/5a", k, mem_addr, mem_wdata); end
    end
    tick;
    checks++; if ({dma_ack, cpu_ack, mem_we} !== 3'b100) begin
      fails++; $display("FAIL dma_write_ack dack/cack/we got=%b exp=100", {dma_ack, cpu_ack, mem_we}); end
    checks++; if (rdata !== 8'hA5) begin fails++; $display("FAIL dma_write_rdata_hold got=%h exp=a5", rdata); end
    dma_req = 1'b0; dma_we = 1'b0;
    tick;
  endtask

  task automatic test_round_robin;
    logic [15:0] order; int got; logic both;
    do_reset;
    collect_grants(4, 1'b0, order, got, both);
    checks++; if (got !== 4) begin fails++; $display("FAIL rr_count got=%0d exp=4", got); end
    checks++; if (order[3:0] !== 4'b1010) begin fails++; $display("FAIL rr_order got=%b exp=1010 (bit0 first, 1=dma)", order[3:0]); end
    checks++; if (both !== 1'b0) begin fails++; $display("FAIL rr_both_gnt got=%b exp=0", both); end
  endtask

  task automatic test_lock;
    logic [15:0] order; int got; logic both;
    do_reset;
    collect_grants(6, 1'b1, order, got, both);
    checks++; if (got !== 6) begin fails++; $display("FAIL lock_count got=%0d exp=6", got); end
    checks++; if (order[5:0] !== 6'b010000) begin fails++; $display("FAIL lock_order got=%b exp=010000 (bit0 first, 1=dma)", order[5:0]); end
    checks++; if (both !== 1'b0) begin fails++; $display("FAIL lock_both_gnt got=%b exp=0", both); end
  endtask

  task automatic test_reset_abort;
    logic [15:0] order; int got; logic both;
    do_reset;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4321;
    tick; tick;
    checks++; if ({mem_en, cpu_gnt} !== 2'b11) begin fails++; $display("FAIL abort_access2 got=%b exp=11", {mem_en, cpu_gnt}); end
    rst = 1'b1;
    tick;
    checks++; if ({cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_en, mem_we} !== 6'b0 || mem_addr !== 16'h0) begin
      fails++; $display("FAIL abort_reset ctl=%b addr=%h exp=000000/0000",
                        {cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_en, mem_we}, mem_addr); end
    rst = 1'b0; cpu_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if ({cpu_ack, dma_ack} !== 2'b00) begin fails++; $display("FAIL abort_no_ack k=%0d got=%b exp=00", k, {cpu_ack, dma_ack}); end
    end
    collect_grants(1, 1'b0, order, got, both);
    checks++; if (got !== 1 || order[0] !== 1'b0) begin
      fails++; $display("FAIL abort_next_tie got=%0d/%b exp=1/0 (cpu)", got, order[0]); end
  endtask

  task automatic test_zero_wait;
    do_reset;
    use_fn = 1'b0; rdata_drv = 8'h3C;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042; cpu_wdata = 8'h77;
    tick;
    checks++; if ({mem_en_z, cpu_gnt_z, dma_gnt_z, cpu_ack_z, mem_we_z} !== 5'b11000) begin
      fails++; $display("FAIL zw_access got=%b exp=11000", {mem_en_z, cpu_gnt_z, dma_gnt_z, cpu_ack_z, mem_we_z}); end
    checks++; if ({mem_addr_z, mem_wdata_z} !== 24'h004277) begin
      fails++; $display("FAIL zw_bus got=%h/%h exp=0042/77", mem_addr_z, mem_wdata_z); end
    tick;
    checks++; if ({mem_en_z, cpu_gnt_z, cpu_ack_z, dma_ack_z} !== 4'b0010) begin
      fails++; $display("FAIL zw_ack got=%b exp=0010", {mem_en_z, cpu_gnt_z, cpu_ack_z, dma_ack_z}); end
    checks++; if (rdata_z !== 8'h3C) begin fails++; $display("FAIL zw_rdata got=%h exp=3c", rdata_z); end
    cpu_req = 1'b0;
    tick;
    checks++; if ({cpu_ack_z, mem_en_z} !== 2'b00) begin fails++; $display("FAIL zw_single_ack got=%b exp=00", {cpu_ack_z, mem_en_z}); end
  endtask

  // Transaction-level reference: each grant owns a fixed time window derived from the wait-state count.
  task automatic test_random;
    int p_grant, free_p, m_run;
    logic have, t_win, t_we, m_last, m_lock_on, in_win, is_ack, w, drop_c, drop_d;
    logic [15:0] t_addr, exp_addr;
    logic [7:0] t_wdata, exp_wdata, exp_rdata;
    logic [5:0] exp_ctl, got_ctl;
    do_reset;
    use_fn = 1'b1;
    p_grant = 0; free_p = 0; m_run = 0; have = 1'b0; t_win = 1'b0; t_we = 1'b0;
    t_addr = '0; t_wdata = '0; m_last = 1'b1; m_lock_on = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    for (int n = 0; n < 3000; n++) begin
      in_win = have && n >= p_grant && n <= p_grant + WS1;
      is_ack = have && n == p_grant + WS1 + 1;
      if (is_ack && !t_we) exp_rdata = fn(t_addr);
      exp_ctl = {in_win && !t_win, in_win && t_win, is_ack && !t_win, is_ack && t_win, in_win, in_win && t_we};
      got_ctl = {cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_en, mem_we};
      checks++; if (got_ctl !== exp_ctl) begin
        fails++; $display("FAIL rnd_ctl cyc=%0d cg/dg/ca/da/en/we got=%b exp=%b", n, got_ctl, exp_ctl); end
      checks++; if (mem_addr !== exp_addr) begin fails++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", n, mem_addr, exp_addr); end
      checks++; if (mem_wdata !== exp_wdata) begin fails++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", n, mem_wdata, exp_wdata); end
      checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", n, rdata, exp_rdata); end
      drop_c = 1'b0; drop_d = 1'b0;
      if (is_ack) begin
        if (t_win) begin dma_req = 1'b0; drop_d = 1'b1; end
        else begin cpu_req = 1'b0; drop_c = 1'b1; end
      end
      if (in_win) begin
        if (t_win) begin dma_addr = 16'($urandom); dma_wdata = 8'($urandom); dma_we = 1'($urandom_range(0, 1)); end
        else begin cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_we = 1'($urandom_range(0, 1)); end
      end
      if (!cpu_req && !drop_c && $urandom_range(0, 2) != 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 16'($urandom);
        cpu_wdata = 8'($urandom); cpu_lock = ($urandom_range(0, 3) != 0);
      end
      if (!dma_req && !drop_d && $urandom_range(0, 2) != 0) begin
        dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1)); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
      end
      if (n + 1 >= free_p && (cpu_req || dma_req)) begin
        if (!dma_req) w = 1'b0;
        else if (!cpu_req) w = 1'b1;
        else if (m_lock_on && m_run < LOCK_MAX1) w = 1'b0;
        else w = !m_last;
        t_win = w;
        t_we = w ? dma_we : cpu_we;
        t_addr = w ? dma_addr : cpu_addr;
        t_wdata = w ? dma_wdata : cpu_wdata;
        p_grant = n + 1; free_p = n + 1 + WS1 + 3; have = 1'b1;
        exp_addr = t_addr; exp_wdata = t_wdata;
        m_last = w;
        if (w) m_run = 0;
        else begin
          m_lock_on = cpu_lock;
          if (!cpu_lock) m_run = 0;
          else if (dma_req) m_run++;
        end
      end
      tick;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; use_fn = 1'b0; rdata_drv = 8'h00;
    cpu_req = 1'b0; cpu_lock = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    tick;
    test_reset;
    test_cpu_read;
    test_dma_write;
    test_round_robin;
    test_lock;
    test_reset_abort;
    test_zero_wait;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Two-port arbiter sharing the CPU's single 8-bit data / 16-bit address memory bus between the CPU core and a DMA engine. It sits between both requesters and the external memory interface. It latches each winning request, drives the memory strobes for a programmable number of wait states, and returns read data with a one-cycle acknowledge. Fairness is round-robin, with a bounded CPU lock for read-modify-write sequences.

## Interface

- WAIT_STATES, default 1: extra memory cycles per access; legal range 0..15.
- LOCK_MAX, default 4: maximum consecutive locked CPU grants while the DMA is requesting; legal range 1..15.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_lock  in  1  sampled at grant; requests CPU priority for the next arbitration.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  access address.
- cpu_wdata  in  8  write data.
- cpu_gnt  out  1  high while the CPU transaction owns the bus.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr[15:0], dma_wdata[7:0]  in  same meaning as the CPU inputs.
- dma_gnt, dma_ack  out  1  same meaning as the CPU outputs.
- rdata  out  8  read data, valid in the ack cycle; shared by both requesters.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, sampled at the end of the last access cycle.

## Operation

- FSM states are IDLE, ACCESS and ACK.
- IDLE:
  - If any req is high, pick a winner.
  - Latch the winner's we, addr and wdata into the mem_* registers.
  - Set gnt, load wcnt = WAIT_STATES, and go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - mem_en=1; mem_we follows the latched we; gnt is held.
  - While wcnt != 0, decrement it.
  - When wcnt == 0, register mem_rdata into rdata (only for reads; rdata holds its value on writes) and go to ACK.
- ACK:
  - Drop mem_en, mem_we and gnt; pulse the winner's ack; go to IDLE.
  - The mem_addr and mem_wdata registers keep their last values.
- Winner selection in IDLE:
  - Single requester: that requester wins.
  - Both requesting, lock active: CPU wins if lock_active and lock_cnt < LOCK_MAX.
  - Both requesting otherwise: the requester not recorded in last_winner wins.
- Bookkeeping:
  - last_winner updates on every grant.
  - lock_active is set on a CPU grant with cpu_lock=1 and cleared on a CPU grant with cpu_lock=0.
  - lock_cnt (4 bits) increments on each CPU grant won through the lock while DMA is requesting.
  - lock_cnt clears on any DMA grant or when lock_active is 0.
  - When lock_cnt reaches LOCK_MAX, the next contested grant goes to the DMA. This bounds DMA starvation.
- Requesters drop req in the cycle after they see ack. A req that is high in the IDLE cycle following ACK is a new request.
- Requester inputs are ignored outside IDLE; changes during ACCESS have no effect.

## Timing

- Reset values:
  - cpu_gnt, dma_gnt, cpu_ack, dma_ack, mem_en, mem_we = 0.
  - mem_addr = 0x0000; mem_wdata = 0x00; rdata = 0x00.
  - State is IDLE; last_winner = DMA, so the CPU wins the first tie; lock_active = 0; lock_cnt = 0.
- req sampled in IDLE at cycle T gives:
  - gnt, mem_en and mem_addr valid from T+1 through T+1+WAIT_STATES.
  - ack and rdata valid at T+2+WAIT_STATES.
- Request-to-ack latency is WAIT_STATES+2 cycles. Back-to-back throughput is one transaction per WAIT_STATES+3 cycles.
- Exactly one of cpu_gnt and dma_gnt is high during ACCESS; both are low in IDLE and ACK.
- At most one ack is high per cycle, and never two ack cycles in a row.
- rst high in any state: the next cycle is IDLE with all outputs at reset values. No ack is issued for an aborted transaction, and rst overrides every other event.
- The wcnt width is 4 bits. With WAIT_STATES = 0, ACCESS lasts exactly one cycle.

## Structure

- Shared package membus_pkg holds:
  - State encoding: ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_ACK = 2'd2.
  - Requester indices: REQ_CPU = 1'b0, REQ_DMA = 1'b1.
- The module is single and flat, with no sub-modules. Winner selection is inline combinational logic feeding the IDLE-state registers.

## Test plan

- CPU read, WAIT_STATES=1: cpu_req at T with addr 0x1234 and mem_rdata=0xA5 -> mem_en=1, mem_addr=0x1234 at T+1..T+2; cpu_ack=1 and rdata=0xA5 at T+3; dma_ack stays 0.
- DMA write 0x5A to 0x8000 -> mem_we=1 and mem_wdata=0x5A at T+1..T+2; dma_ack at T+3; rdata unchanged.
- Both requesting continuously with cpu_lock=0, after reset -> grant order is CPU, DMA, CPU, DMA; gnt is never high for both.
- Both requesting, cpu_lock=1, LOCK_MAX=4 -> four consecutive CPU grants, then one DMA grant, then CPU again.
- rst asserted in the second ACCESS cycle -> next cycle mem_en=0, gnt=0, no ack issued; the next tie goes to the CPU.
- WAIT_STATES=0, cpu_req at T -> mem_en only at T+1; cpu_ack at T+2.
